stream_reverse_buffer: RTL
==========================

Name: stream_reverse_buffer

Overview:
- Sequential, streaming counterpart of the combinational array reverser.
- Accepts a frame of exactly N elements serially over a valid/ready input port, stores them, then emits them one per handshake in reversed order (last in, first out) on a valid/ready output port.
- Sits between a serial element producer and a consumer that needs frame-reversed order, where a full parallel in_array/out_array bus is too wide.

Parameters:
- N, 5, elements per frame; legal range N >= 2.
- WIDTH, 8, bits per element.
- CW, $clog2(N) (minimum 1), index/counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  block can accept an element.
- in_data  input  WIDTH  element value.
- out_valid  output  1  out_data holds a valid reversed element.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  reversed element; 0 when out_valid=0.
- out_last  output  1  high with the final element of the frame (original element 0).
- frame_done  output  1  one-cycle pulse in the cycle after the final output handshake.

Behaviour:
- Storage: mem[0:N-1] of WIDTH bits. Write pointer wr_idx and read pointer rd_idx are CW bits wide.
- State FILL (reset state):
  - in_ready=1 and out_valid=0.
  - Input handshake (in_valid & in_ready): mem[wr_idx] <= in_data, then wr_idx increments.
  - On the handshake with wr_idx==N-1: wr_idx <= 0, rd_idx <= N-1, next state DRAIN.
- State DRAIN:
  - in_ready=0 and out_valid=1.
  - out_data=mem[rd_idx] (combinational read of registered storage).
  - out_last=(rd_idx==0).
  - Output handshake (out_valid & out_ready): rd_idx decrements.
  - On the handshake with rd_idx==0: next state FILL, and frame_done=1 in the following cycle.
- Latency:
  - First output is valid in the cycle immediately after the Nth input handshake.
  - Minimum frame turnaround is 2N cycles. Input and output never overlap.
  - in_ready returns to 1 in the cycle after the last output handshake.
- Backpressure:
  - out_ready=0 holds out_data and out_last stable and leaves rd_idx unchanged, for any number of cycles.
  - in_valid=0 during FILL leaves wr_idx unchanged. Gaps between elements are allowed.
- Ignored inputs: in_valid asserted during DRAIN has no effect. in_data is never sampled then.
- Output gating: out_data=0 and out_last=0 whenever out_valid=0.
- Reset (synchronous, rst=1 at a clock edge):
  - State goes to FILL; wr_idx=0, rd_idx=0, frame_done=0.
  - in_ready=1 from the first cycle after reset; out_valid=0, out_data=0, out_last=0.
  - mem contents are don't-care and need not be cleared.
- Reset mid-operation: any partially filled or partially drained frame is discarded. No residual element is ever emitted.
- Pointer rules: no wrap-around beyond N-1. wr_idx never exceeds N-1 and rd_idx never underflows; both terminal cases are handled explicitly above.

Test Plan:
- Basic frame: reset, then feed 1,2,3,4,5 with in_valid held and out_ready=1.
  - Required: outputs 5,4,3,2,1 on consecutive cycles.
  - out_last high only with 1; frame_done pulse one cycle later; in_ready low throughout DRAIN.
- Input gaps: feed 10,20,30,40,50 with in_valid low for 2 cycles between elements.
  - Required: wr_idx holds during the gaps; output is 50,40,30,20,10.
- Output backpressure: after filling 1..5, toggle out_ready 1,0,0,1,0,1,1,1.
  - Required: each value holds while out_ready=0; the sequence is still 5,4,3,2,1; out_last only with 1.
- Back-to-back frames: feed 1..5, drain, then feed 6..10 immediately.
  - Required: outputs 5..1 then 10..6; in_valid pulses asserted during DRAIN are not captured.
- Reset mid-operation:
  - Assert rst after 3 inputs: in_ready=1 and out_valid=0 next cycle; a following frame 7,8,9,10,11 outputs 11,10,9,8,7.
  - Assert rst after 2 outputs of a frame: out_valid=0 next cycle and no remaining elements appear.
- Parameter sweep: N=2 and WIDTH=16.
  - Input 0xABCD, 0x1234 -> output 0x1234 then 0xABCD (with out_last).

Source files
------------

// File: rtl/stream_reverse_buffer.sv
// Collects an N-element frame serially, then replays it last-in-first-out; first output one cycle after the Nth input.
// Input and output phases never overlap; out_ready=0 freezes the output element indefinitely.
module stream_reverse_buffer #(
    parameter int N     = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             frame_done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
    localparam logic [CW-1:0] IDX_ONE  = CW'(1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q,      state_d;
    logic [CW-1:0]   wr_idx_q,     wr_idx_d;
    logic [CW-1:0]   rd_idx_q,     rd_idx_d;
    logic            in_ready_q,   in_ready_d;
    logic            out_valid_q,  out_valid_d;
    logic            frame_done_q, frame_done_d;

    logic [WIDTH-1:0] mem_q [N];

    logic in_hs;
    logic out_hs;
    logic wr_en;

    // Handshakes use the registered ready/valid so each phase only reacts in its own state.
    assign in_hs  = in_valid  & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            FILL: begin
                if (in_hs) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d    = '0;
                        rd_idx_d    = IDX_LAST;
                        state_d     = DRAIN;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_ONE;
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (rd_idx_q == '0) begin
                        state_d      = FILL;
                        in_ready_d   = 1'b1;
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q - IDX_ONE;
                    end
                end
            end
            default: begin
                state_d     = FILL;
                wr_idx_d    = '0;
                rd_idx_d    = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is never cleared; the pointers alone decide what is ever read out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx_q] <= in_data;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_valid_q ? mem_q[rd_idx_q] : '0;
    assign out_last   = out_valid_q & (rd_idx_q == '0);
    assign frame_done = frame_done_q;

endmodule
